// File: rtl/fifo_pkg.sv
// fifo_pkg: depth/pointer-width derivations and Gray conversions shared by both FIFO pointer sides.
package fifo_pkg;
   localparam int GW = 32;
   function automatic int fifo_depth(input int aw);
      return 1 << aw;
   endfunction
   function automatic int ptr_width(input int aw);
      return aw + 1;
   endfunction
   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
      logic [GW-1:0] b;
      b[GW-1] = g[GW-1];
      for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/w_ptr_ctrl_if.sv
// w_ptr_ctrl_if: producer/memory/read-side signals of the FIFO write pointer controller.
interface w_ptr_ctrl_if #(parameter int ADDR_WIDTH = 3);
   logic                  w_en;
   logic                  w_ovf_clr;
   logic [ADDR_WIDTH:0]   r_gptr;
   logic                  w_mem_en;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH:0]   w_gptr;
   logic                  w_full;
   logic                  w_almost_full;
   logic [ADDR_WIDTH:0]   w_level;
   logic                  w_overflow;
   modport master (
      output w_en, w_ovf_clr, r_gptr,
      input  w_mem_en, w_addr, w_gptr, w_full, w_almost_full, w_level, w_overflow
   );
   modport slave (
      input  w_en, w_ovf_clr, r_gptr,
      output w_mem_en, w_addr, w_gptr, w_full, w_almost_full, w_level, w_overflow
   );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(parameter int WIDTH = 4) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= '0;
         q  <= '0;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end
endmodule

// File: rtl/w_ptr_ctrl.sv
// w_ptr_ctrl: async FIFO write-side pointers, full/almost-full, fill level and sticky overflow.
module w_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_MARGIN  = 2
) (
   input  logic        w_clk,
   input  logic        w_rst,
   w_ptr_ctrl_if.slave bus
);
   localparam int PW    = ptr_width(ADDR_WIDTH);
   localparam int DEPTH = fifo_depth(ADDR_WIDTH);
   logic [PW-1:0] w_bptr, w_gptr, w_bnext, w_gnext, rq2, rq2_bin;
   logic          w_inc, w_full, w_almost_full, w_overflow;
   sync_2ff #(.WIDTH(PW)) u_rsync (
      .clk(w_clk),
      .rst(w_rst),
      .d  (bus.r_gptr),
      .q  (rq2)
   );
   assign w_inc   = bus.w_en & ~w_full;
   assign w_bnext = w_bptr + PW'(w_inc);
   assign w_gnext = PW'(bin2gray(GW'(w_bnext)));
   assign rq2_bin = PW'(gray2bin(GW'(rq2)));
   // full when the next write pointer laps the synchronized read pointer by exactly DEPTH
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         w_bptr        <= '0;
         w_gptr        <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_overflow    <= 1'b0;
      end else begin
         w_bptr        <= w_bnext;
         w_gptr        <= w_gnext;
         w_full        <= w_gnext == {~rq2[PW-1:PW-2], rq2[PW-3:0]};
         w_almost_full <= (w_bnext - rq2_bin) >= PW'(DEPTH - AF_MARGIN);
         w_overflow    <= (bus.w_en & w_full) | (w_overflow & ~bus.w_ovf_clr);
      end
   end
   assign bus.w_mem_en      = w_inc;
   assign bus.w_addr        = w_bptr[ADDR_WIDTH-1:0];
   assign bus.w_gptr        = w_gptr;
   assign bus.w_full        = w_full;
   assign bus.w_almost_full = w_almost_full;
   assign bus.w_level       = w_bptr - rq2_bin;
   assign bus.w_overflow    = w_overflow;
endmodule

// File: tb/tb_w_ptr_ctrl.sv
// tb_w_ptr_ctrl: directed vector table plus hand sequences for w_ptr_ctrl (ADDR_WIDTH=3, AF_MARGIN=2).
module tb_w_ptr_ctrl;
   logic w_clk = 1'b0;
   logic w_rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   w_ptr_ctrl_if #(.ADDR_WIDTH(3)) bus ();
   w_ptr_ctrl #(.ADDR_WIDTH(3), .AF_MARGIN(2)) dut (
      .w_clk(w_clk),
      .w_rst(w_rst),
      .bus  (bus)
   );
   always #5 w_clk = ~w_clk;
   typedef struct {
      logic       en;
      logic       clr;
      logic [3:0] rg;
      logic       mem;
      logic [2:0] addr;
      logic [3:0] gptr;
      logic       full;
      logic       af;
      logic [3:0] lvl;
      logic       ovf;
   } vec_t;
   vec_t tbl [17];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic step();
      @(posedge w_clk);
      #1;
   endtask
   function automatic logic [3:0] g4(input int k);
      logic [3:0] b;
      b = 4'(k);
      return b ^ (b >> 1);
   endfunction
   task automatic chk_zero(input string tag);
      chk({tag, "_mem"}, int'(bus.w_mem_en), 0);
      chk({tag, "_addr"}, int'(bus.w_addr), 0);
      chk({tag, "_gptr"}, int'(bus.w_gptr), 0);
      chk({tag, "_full"}, int'(bus.w_full), 0);
      chk({tag, "_af"}, int'(bus.w_almost_full), 0);
      chk({tag, "_lvl"}, int'(bus.w_level), 0);
      chk({tag, "_ovf"}, int'(bus.w_overflow), 0);
   endtask
   task automatic do_reset(input string tag);
      bus.w_en = 1'b0;
      bus.w_ovf_clr = 1'b0;
      bus.r_gptr = '0;
      #2 w_rst = 1'b1;
      #1 chk_zero(tag);
      #2 w_rst = 1'b0;
   endtask
   initial begin
      bus.w_en = 1'b0;
      bus.w_ovf_clr = 1'b0;
      bus.r_gptr = '0;
      tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd1, 4'h1, 1'b0, 1'b0, 4'd1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd2, 4'h3, 1'b0, 1'b0, 4'd2, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd3, 4'h2, 1'b0, 1'b0, 4'd3, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd4, 4'h6, 1'b0, 1'b0, 4'd4, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd5, 4'h7, 1'b0, 1'b0, 4'd5, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd6, 4'h5, 1'b0, 1'b1, 4'd6, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd7, 4'h4, 1'b0, 1'b1, 4'd7, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 4'h0, 1'b1, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 4'h1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 4'h1, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd7, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 4'h1, 1'b0, 3'd0, 4'hC, 1'b0, 1'b1, 4'd7, 1'b0};
      tbl[16] = '{1'b1, 1'b0, 4'h1, 1'b1, 3'd1, 4'hD, 1'b1, 1'b1, 4'd8, 1'b0};
      step();
      step();
      chk_zero("reset");
      w_rst = 1'b0;
      step();
      // fill, overflow and release driven from the vector table
      for (int i = 0; i < 17; i++) begin
         bus.w_en = tbl[i].en;
         bus.w_ovf_clr = tbl[i].clr;
         bus.r_gptr = tbl[i].rg;
         #1 chk($sformatf("v%0d_mem", i), int'(bus.w_mem_en), int'(tbl[i].mem));
         step();
         chk($sformatf("v%0d_addr", i), int'(bus.w_addr), int'(tbl[i].addr));
         chk($sformatf("v%0d_gptr", i), int'(bus.w_gptr), int'(tbl[i].gptr));
         chk($sformatf("v%0d_full", i), int'(bus.w_full), int'(tbl[i].full));
         chk($sformatf("v%0d_af", i), int'(bus.w_almost_full), int'(tbl[i].af));
         chk($sformatf("v%0d_lvl", i), int'(bus.w_level), int'(tbl[i].lvl));
         chk($sformatf("v%0d_ovf", i), int'(bus.w_overflow), int'(tbl[i].ovf));
      end
      // wrap: read pointer follows the write count, synchronizer adds a 2-entry lag
      do_reset("rst_wrap");
      for (int k = 1; k <= 20; k++) begin
         bus.w_en = 1'b1;
         step();
         bus.r_gptr = g4(k);
         chk($sformatf("wrap%0d_gptr", k), int'(bus.w_gptr), int'(g4(k)));
         chk($sformatf("wrap%0d_addr", k), int'(bus.w_addr), k % 8);
         chk($sformatf("wrap%0d_full", k), int'(bus.w_full), 0);
         chk($sformatf("wrap%0d_af", k), int'(bus.w_almost_full), 0);
         chk($sformatf("wrap%0d_lvl", k), int'(bus.w_level), (k < 2) ? k : 2);
      end
      bus.w_en = 1'b0;
      step();
      // asynchronous reset mid-operation
      do_reset("rst_pre");
      bus.w_en = 1'b1;
      for (int k = 0; k < 5; k++) step();
      chk("pre_lvl", int'(bus.w_level), 5);
      do_reset("rst_mid");
      bus.w_en = 1'b1;
      #1 chk("post_mem", int'(bus.w_mem_en), 1);
      chk("post_addr0", int'(bus.w_addr), 0);
      step();
      bus.w_en = 1'b0;
      chk("post_addr1", int'(bus.w_addr), 1);
      chk("post_gptr", int'(bus.w_gptr), 1);
      chk("post_lvl", int'(bus.w_level), 1);
      step();
      // simultaneous filling write and read advance at level 7
      do_reset("rst_sim");
      bus.w_en = 1'b1;
      for (int k = 0; k < 7; k++) step();
      chk("sim_lvl7", int'(bus.w_level), 7);
      chk("sim_full0", int'(bus.w_full), 0);
      bus.r_gptr = 4'h1;
      #1 chk("sim_mem", int'(bus.w_mem_en), 1);
      step();
      bus.w_en = 1'b0;
      chk("sim_e1_full", int'(bus.w_full), 1);
      chk("sim_e1_lvl", int'(bus.w_level), 8);
      step();
      chk("sim_e2_full", int'(bus.w_full), 1);
      chk("sim_e2_lvl", int'(bus.w_level), 7);
      step();
      chk("sim_e3_full", int'(bus.w_full), 0);
      chk("sim_e3_gptr", int'(bus.w_gptr), 12);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
